mem_port_arbiter: RTL

Two-master, one-slave arbiter for the sram-like memory bus. It merges the CPU's instruction-fetch port (`inst_sram_*`) and data-access port (`data_sram_*`) onto a single sram-like port (`mem_*`) toward the bridge or cache. It supports pipelined outstanding transactions: accepted requests are remembered in order so each `data_ok` is routed back to the master that issued it. It sits between the CPU top level and the AXI bridge.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_id_fifo.sv | 60 ++++++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants and request bundle for the two-master sram-like arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    localparam int DEFAULT_OUTSTANDING = 4;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int SIZE_W  = 2;
    localparam int WSTRB_W = 4;

    // One sram-like request, everything except the req strobe itself.
    typedef struct packed {
        logic               wr;
        logic [SIZE_W-1:0]  size;
        logic [WSTRB_W-1:0] wstrb;
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  wdata;
    } sram_req_t;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of 1-bit master IDs for accepted but uncompleted transactions.
// Latency: push visible at head one cycle later; head/full/empty are registered-state decodes.
// Backpressure: push ignored when full, pop ignored when empty; caller gates both.
//
// Ports: clk, rst_n (async active-low), push/push_id, pop, full, empty, head.
module mem_arb_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_OUTSTANDING
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [DEPTH-1:0] ids;
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = ids[rptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers are exactly log2(DEPTH) bits so they wrap for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ids   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                ids[wptr] <= push_id;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges the inst and data sram-like masters onto one sram-like slave port, routing data_ok back in order.
// Latency: 0 cycles request/addr_ok/data_ok paths; up to OUTSTANDING transactions in flight.
// Backpressure: mem_req held off while OUTSTANDING IDs are pending; a stalled request is locked until accepted.
//
// Ports: inst_sram_* (master 0), data_sram_* (master 1), mem_* (slave), arb_err (sticky protocol error).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int OUTSTANDING = DEFAULT_OUTSTANDING,
    parameter bit DATA_PRIO   = 1'b1
) (
    input  logic               clk,
    input  logic               resetn,

    input  logic               inst_sram_req,
    input  logic               inst_sram_wr,
    input  logic [SIZE_W-1:0]  inst_sram_size,
    input  logic [WSTRB_W-1:0] inst_sram_wstrb,
    input  logic [ADDR_W-1:0]  inst_sram_addr,
    input  logic [DATA_W-1:0]  inst_sram_wdata,
    output logic               inst_sram_addr_ok,
    output logic [ADDR_W-1:0]  inst_sram_addr_ok_addr,
    output logic               inst_sram_data_ok,
    output logic [DATA_W-1:0]  inst_sram_rdata,

    input  logic               data_sram_req,
    input  logic               data_sram_wr,
    input  logic [SIZE_W-1:0]  data_sram_size,
    input  logic [WSTRB_W-1:0] data_sram_wstrb,
    input  logic [ADDR_W-1:0]  data_sram_addr,
    input  logic [DATA_W-1:0]  data_sram_wdata,
    output logic               data_sram_addr_ok,
    output logic               data_sram_data_ok,
    output logic [DATA_W-1:0]  data_sram_rdata,

    output logic               mem_req,
    output logic               mem_wr,
    output logic [SIZE_W-1:0]  mem_size,
    output logic [WSTRB_W-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_addr_ok,
    input  logic               mem_data_ok,
    input  logic [DATA_W-1:0]  mem_rdata,

    output logic               arb_err
);

    sram_req_t inst_fields;
    sram_req_t data_fields;
    sram_req_t sel_fields;

    logic lock_q;
    logic lock_id_q;
    logic last_id_q;
    logic arb_err_q;

    logic sel;
    logic sel_req;
    logic full;
    logic empty;
    logic head;
    logic handshake;
    logic stall;
    logic lock_drop;
    logic resp_vld;

    assign inst_fields = '{wr: inst_sram_wr, size: inst_sram_size, wstrb: inst_sram_wstrb,
                           addr: inst_sram_addr, wdata: inst_sram_wdata};
    assign data_fields = '{wr: data_sram_wr, size: data_sram_size, wstrb: data_sram_wstrb,
                           addr: data_sram_addr, wdata: data_sram_wdata};

    // A locked grant wins over everything so the slave sees a stable request.
    always_comb begin
        sel = ID_INST;
        if (lock_q) begin
            sel = lock_id_q;
        end else if (inst_sram_req && data_sram_req) begin
            sel = DATA_PRIO ? ID_DATA : ~last_id_q;
        end else if (data_sram_req) begin
            sel = ID_DATA;
        end
    end

    assign sel_req    = (sel == ID_DATA) ? data_sram_req : inst_sram_req;
    assign sel_fields = (sel == ID_DATA) ? data_fields : inst_fields;

    // full depends only on registered count, so data_ok never reaches mem_req combinationally.
    assign mem_req = sel_req & ~full;
    assign {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} = sel_fields;

    assign handshake = mem_req & mem_addr_ok;
    assign stall     = mem_req & ~mem_addr_ok;
    assign lock_drop = lock_q & ~sel_req;

    assign inst_sram_addr_ok = handshake & (sel == ID_INST);
    assign data_sram_addr_ok = handshake & (sel == ID_DATA);
    // Driven on every accepted address; consumers qualify it with inst_sram_addr_ok.
    assign inst_sram_addr_ok_addr = handshake ? mem_addr : '0;

    assign resp_vld          = mem_data_ok & ~empty;
    assign inst_sram_data_ok = resp_vld & (head == ID_INST);
    assign data_sram_data_ok = resp_vld & (head == ID_DATA);
    assign inst_sram_rdata   = mem_rdata;
    assign data_sram_rdata   = mem_rdata;

    assign arb_err = arb_err_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_q    <= 1'b0;
            lock_id_q <= ID_INST;
            last_id_q <= ID_INST;
            arb_err_q <= 1'b0;
        end else begin
            if (handshake) begin
                lock_q    <= 1'b0;
                last_id_q <= sel;
            end else if (stall) begin
                lock_q    <= 1'b1;
                lock_id_q <= sel;
            end else if (lock_drop) begin
                lock_q    <= 1'b0;
            end
            if (lock_drop || (mem_data_ok && empty)) begin
                arb_err_q <= 1'b1;
            end
        end
    end

    mem_arb_id_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (resetn),
        .push    (handshake),
        .push_id (sel),
        .pop     (resp_vld),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

endmodule
